// File: rtl/sprite_comp_pkg.sv
// Shared constants and helpers for the sprite layer compositor.
//
// Contents:
//   PIPE_LAT          - stream latency of the compositor in clock cycles
//   DEFAULT_RGB_W     - default colour width per channel
//   lsi_t             - result of a lowest-set-bit search (found flag + index)
//   lowest_set_index  - priority search over a 64-bit vector, bit 0 wins
package sprite_comp_pkg;

    localparam int PIPE_LAT      = 3;
    localparam int DEFAULT_RGB_W = 3;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } lsi_t;

    // Scans from the top down so the last hit written is the lowest index.
    function automatic lsi_t lowest_set_index(input logic [63:0] vec);
        lsi_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 6'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_group_prio.sv
// One priority group of the compositor: picks the lowest-indexed drawing
// channel inside the group and registers its colour plus a group-hit flag.
//
// Ports:
//   clk_i    - pixel clock
//   reset_i  - synchronous active-high reset
//   d_i      - per-channel draw request (valid & active), bit 0 highest priority
//   rgb_i    - per-channel colour, channel i at [i*RGB_W +: RGB_W]
//   rgb_o    - registered colour of the group winner (0 when nobody draws)
//   any_o    - registered flag: some channel of the group draws
module sprite_group_prio
    import sprite_comp_pkg::*;
#(
    parameter int GROUP = 8,
    parameter int RGB_W = DEFAULT_RGB_W
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [GROUP-1:0]       d_i,
    input  logic [GROUP*RGB_W-1:0] rgb_i,
    output logic [RGB_W-1:0]       rgb_o,
    output logic                   any_o
);

    logic [63:0]      vec;
    lsi_t             win;
    logic [RGB_W-1:0] rgb_d;
    logic [RGB_W-1:0] rgb_q;
    logic             any_d;
    logic             any_q;

    // Find the winning channel and mux out its colour. The mux is written
    // as a compare loop so the select never indexes past the group.
    always_comb begin
        vec            = '0;
        vec[GROUP-1:0] = d_i;
        win            = lowest_set_index(vec);
        any_d          = win.found;
        rgb_d          = '0;
        for (int i = 0; i < GROUP; i++) begin
            if (win.found && (int'(win.idx) == i)) begin
                rgb_d = rgb_i[i*RGB_W +: RGB_W];
            end
        end
    end

    // Stage-2 group registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rgb_q <= '0;
            any_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            any_q <= any_d;
        end
    end

    assign rgb_o = rgb_q;
    assign any_o = any_q;

endmodule

// File: rtl/sprite_layer_compositor.sv
// Pipelined sprite compositor: merges CH_COUNT sprite channels into one
// pixel stream (lowest channel index wins), keeps video_on/hsync/vsync
// aligned with the colour (3-cycle latency), and gathers per-channel
// class A vs class B collisions over a frame, publishing them once per frame.
//
// Ports:
//   clk25, reset                     - pixel clock, synchronous active-high reset
//   ch_valid_flat, ch_active_flat    - per-channel box hit and alive flags
//   ch_rgb_flat                      - per-channel colour, channel i at [i*RGB_W +: RGB_W]
//   video_on_in, hsync_in, vsync_in  - timing from the VGA controller
//   coll_clear                       - clears published flags and the accumulator
//   rgb_out, draw_out                - composited colour, some channel drew
//   video_on_out, hsync_out, vsync_out - timing delayed to match rgb_out
//   coll_flags, coll_any             - collisions of the last completed frame
//   frame_tick                       - one-cycle pulse when coll_flags update
module sprite_layer_compositor
    import sprite_comp_pkg::*;
#(
    parameter int               CH_COUNT     = 32,
    parameter int               RGB_W        = DEFAULT_RGB_W,
    parameter int               GROUP        = 8,
    parameter logic [63:0]      CLASS_A_MASK = 64'h0000_0000_0000_01FF,
    parameter logic [63:0]      CLASS_B_MASK = 64'h0000_0000_FFFF_FE00,
    parameter logic [RGB_W-1:0] BG_RGB       = '0,
    parameter logic             SYNC_ACTIVE  = 1'b0
) (
    input  logic                      clk25,
    input  logic                      reset,
    input  logic [CH_COUNT-1:0]       ch_valid_flat,
    input  logic [CH_COUNT-1:0]       ch_active_flat,
    input  logic [CH_COUNT*RGB_W-1:0] ch_rgb_flat,
    input  logic                      video_on_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      coll_clear,
    output logic [RGB_W-1:0]          rgb_out,
    output logic                      draw_out,
    output logic                      video_on_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic [CH_COUNT-1:0]       coll_flags,
    output logic                      coll_any,
    output logic                      frame_tick
);

    localparam int N_GRP = (CH_COUNT + GROUP - 1) / GROUP;
    localparam int PAD_W = N_GRP * GROUP;

    // A channel listed in both masks is treated as class A only.
    localparam logic [CH_COUNT-1:0] IS_A = CLASS_A_MASK[CH_COUNT-1:0];
    localparam logic [CH_COUNT-1:0] IS_B = CLASS_B_MASK[CH_COUNT-1:0] & ~IS_A;

    localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

    // Stage 1 registers
    logic [CH_COUNT-1:0]       d1_q;
    logic [CH_COUNT*RGB_W-1:0] rgb1_q;
    logic                      vid1_q, hs1_q, vs1_q;

    // Stage 2 registers (group winners live inside sprite_group_prio)
    logic [CH_COUNT-1:0]       d2_q;
    logic                      a_any2_q, b_any2_q;
    logic                      vid2_q, hs2_q, vs2_q;
    logic [PAD_W-1:0]          d_pad;
    logic [PAD_W*RGB_W-1:0]    rgb_pad;
    logic [N_GRP*RGB_W-1:0]    grp_rgb;
    logic [N_GRP-1:0]          grp_any;

    // Stage 3 registers and next-state
    logic [RGB_W-1:0]          rgb_d, rgb_q;
    logic                      draw_d, draw_q;
    logic                      vid3_q, hs3_q, vs3_q;
    logic [CH_COUNT-1:0]       cp;
    logic                      boundary;
    logic [CH_COUNT-1:0]       acc_d, acc_q;
    logic [CH_COUNT-1:0]       flags_d, flags_q;
    logic                      any_q;
    logic                      tick_q;

    // Stage 1: capture the per-channel draw requests, colours and timing.
    always_ff @(posedge clk25) begin
        if (reset) begin
            d1_q   <= '0;
            rgb1_q <= '0;
            vid1_q <= 1'b0;
            hs1_q  <= SYNC_IDLE;
            vs1_q  <= SYNC_IDLE;
        end else begin
            d1_q   <= ch_valid_flat & ch_active_flat;
            rgb1_q <= ch_rgb_flat;
            vid1_q <= video_on_in;
            hs1_q  <= hsync_in;
            vs1_q  <= vsync_in;
        end
    end

    // Pad the channel vectors to whole groups; the missing channels of a
    // partial last group never draw.
    always_comb begin
        d_pad                        = '0;
        rgb_pad                      = '0;
        d_pad[CH_COUNT-1:0]          = d1_q;
        rgb_pad[CH_COUNT*RGB_W-1:0]  = rgb1_q;
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
        sprite_group_prio #(
            .GROUP (GROUP),
            .RGB_W (RGB_W)
        ) u_prio (
            .clk_i   (clk25),
            .reset_i (reset),
            .d_i     (d_pad[g*GROUP +: GROUP]),
            .rgb_i   (rgb_pad[g*GROUP*RGB_W +: GROUP*RGB_W]),
            .rgb_o   (grp_rgb[g*RGB_W +: RGB_W]),
            .any_o   (grp_any[g])
        );
    end

    // Stage 2: delay the draw vector and timing, and summarise which
    // classes are present on this pixel for the collision check.
    always_ff @(posedge clk25) begin
        if (reset) begin
            d2_q     <= '0;
            a_any2_q <= 1'b0;
            b_any2_q <= 1'b0;
            vid2_q   <= 1'b0;
            hs2_q    <= SYNC_IDLE;
            vs2_q    <= SYNC_IDLE;
        end else begin
            d2_q     <= d1_q;
            a_any2_q <= |(d1_q & IS_A);
            b_any2_q <= |(d1_q & IS_B);
            vid2_q   <= vid1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
        end
    end

    // Stage 3 colour: the lowest group with a hit wins, background otherwise,
    // and blanking forces black.
    always_comb begin
        rgb_d = BG_RGB;
        for (int g = N_GRP - 1; g >= 0; g--) begin
            if (grp_any[g]) begin
                rgb_d = grp_rgb[g*RGB_W +: RGB_W];
            end
        end
        if (!vid2_q) begin
            rgb_d = '0;
        end
        draw_d = (|grp_any) & vid2_q;
    end

    // Collision bookkeeping. A channel collides when it draws and the opposite
    // class also draws on the same visible pixel. The frame boundary is the
    // entry of the stage-3 vsync into its active level; that pixel's own
    // collisions still belong to the frame being published.
    always_comb begin
        cp = '0;
        if (vid2_q) begin
            cp = d2_q & ((IS_A & {CH_COUNT{b_any2_q}}) | (IS_B & {CH_COUNT{a_any2_q}}));
        end
        boundary = (vs2_q == SYNC_ACTIVE) && (vs3_q != SYNC_ACTIVE);
        flags_d  = flags_q;
        acc_d    = acc_q | cp;
        if (coll_clear) begin
            flags_d = '0;
            acc_d   = '0;
        end else if (boundary) begin
            flags_d = acc_q | cp;
            acc_d   = '0;
        end
    end

    // Stage 3 registers: stream outputs plus the collision state.
    always_ff @(posedge clk25) begin
        if (reset) begin
            rgb_q   <= '0;
            draw_q  <= 1'b0;
            vid3_q  <= 1'b0;
            hs3_q   <= SYNC_IDLE;
            vs3_q   <= SYNC_IDLE;
            acc_q   <= '0;
            flags_q <= '0;
            any_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            draw_q  <= draw_d;
            vid3_q  <= vid2_q;
            hs3_q   <= hs2_q;
            vs3_q   <= vs2_q;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            any_q   <= |flags_d;
            tick_q  <= boundary;
        end
    end

    assign rgb_out      = rgb_q;
    assign draw_out     = draw_q;
    assign video_on_out = vid3_q;
    assign hsync_out    = hs3_q;
    assign vsync_out    = vs3_q;
    assign coll_flags   = flags_q;
    assign coll_any     = any_q;
    assign frame_tick   = tick_q;

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Self-checking bench for sprite_layer_compositor. A reference model built
// from the behavioural rules (lowest index wins, class A vs class B
// collisions, publish on vsync entering its active level) predicts every
// output each cycle; directed scenarios add absolute expectations.
module tb_sprite_layer_compositor;
    import sprite_comp_pkg::*;

    localparam int             CH     = 32;
    localparam int             RW     = DEFAULT_RGB_W;
    localparam logic [63:0]    MASK_A = 64'h0000_0000_0000_01FF;
    localparam logic [63:0]    MASK_B = 64'h0000_0000_FFFF_FE00;
    localparam logic [RW-1:0]  BG     = 3'b000;
    localparam logic           SA     = 1'b0;
    localparam logic           SI     = 1'b1;
    localparam logic [CH-1:0]  ALL    = '1;
    localparam logic [CH-1:0]  NONE   = '0;

    logic              clk25 = 1'b0;
    logic              reset;
    logic [CH-1:0]     ch_valid_flat;
    logic [CH-1:0]     ch_active_flat;
    logic [CH*RW-1:0]  ch_rgb_flat;
    logic              video_on_in, hsync_in, vsync_in, coll_clear;
    logic [RW-1:0]     rgb_out;
    logic              draw_out, video_on_out, hsync_out, vsync_out;
    logic [CH-1:0]     coll_flags;
    logic              coll_any, frame_tick;

    sprite_layer_compositor dut (
        .clk25          (clk25),
        .reset          (reset),
        .ch_valid_flat  (ch_valid_flat),
        .ch_active_flat (ch_active_flat),
        .ch_rgb_flat    (ch_rgb_flat),
        .video_on_in    (video_on_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .coll_clear     (coll_clear),
        .rgb_out        (rgb_out),
        .draw_out       (draw_out),
        .video_on_out   (video_on_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .coll_flags     (coll_flags),
        .coll_any       (coll_any),
        .frame_tick     (frame_tick)
    );

    always #5 clk25 = ~clk25;

    typedef struct {
        logic [RW-1:0] rgb;
        logic          draw;
        logic          vid;
        logic          hs;
        logic          vs;
        logic [CH-1:0] cp;
    } pix_t;

    pix_t          pipeQ[$];
    pix_t          curM;
    pix_t          resetPix;
    logic [CH-1:0] accM, flagsM;
    logic          anyM, tickM, prevVsM;
    logic [CH*RW-1:0] rgbVec;
    int            errors = 0;
    int            checks = 0;
    int            tickSeen = 0;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit isA(input int i);
        return MASK_A[i];
    endfunction

    function automatic bit isB(input int i);
        return MASK_B[i] && !MASK_A[i];
    endfunction

    // Expected outputs and collision contribution of one input pixel.
    function automatic pix_t makePixel(input logic [CH-1:0] v, input logic [CH-1:0] a,
                                       input logic [CH*RW-1:0] rgb,
                                       input logic vid, input logic hs, input logic vs);
        pix_t          p;
        logic [CH-1:0] d;
        bit            found, aHit, bHit;
        d     = v & a;
        p.rgb = BG;
        found = 0;
        for (int i = 0; i < CH; i++) begin
            if (d[i] && !found) begin
                p.rgb = rgb[i*RW +: RW];
                found = 1;
            end
        end
        if (!vid) p.rgb = '0;
        p.draw = found && vid;
        aHit = 0;
        bHit = 0;
        for (int i = 0; i < CH; i++) begin
            if (d[i] && isA(i)) aHit = 1;
            if (d[i] && isB(i)) bHit = 1;
        end
        p.cp = '0;
        if (vid) begin
            for (int i = 0; i < CH; i++) begin
                if (d[i]) p.cp[i] = isA(i) ? bHit : (isB(i) ? aHit : 1'b0);
            end
        end
        p.vid = vid;
        p.hs  = hs;
        p.vs  = vs;
        return p;
    endfunction

    // Drive one pixel, clock it, advance the model, then compare all outputs.
    task automatic applyStimulus(input logic [CH-1:0] v, input logic [CH-1:0] a,
                                 input logic vid, input logic hs, input logic vs,
                                 input logic clr, input logic rst);
        bit boundary;
        ch_valid_flat  = v;
        ch_active_flat = a;
        ch_rgb_flat    = rgbVec;
        video_on_in    = vid;
        hsync_in       = hs;
        vsync_in       = vs;
        coll_clear     = clr;
        reset          = rst;
        @(posedge clk25);
        if (rst) begin
            pipeQ.delete();
            pipeQ.push_back(resetPix);
            pipeQ.push_back(resetPix);
            curM    = resetPix;
            accM    = '0;
            flagsM  = '0;
            anyM    = 1'b0;
            tickM   = 1'b0;
            prevVsM = SI;
        end else begin
            pipeQ.push_back(makePixel(v, a, rgbVec, vid, hs, vs));
            if (pipeQ.size() > PIPE_LAT) pipeQ.pop_front();
            curM     = pipeQ[0];
            boundary = (curM.vs == SA) && (prevVsM != SA);
            tickM    = boundary;
            if (clr) begin
                flagsM = '0;
                accM   = '0;
            end else if (boundary) begin
                flagsM = accM | curM.cp;
                accM   = '0;
            end else begin
                accM = accM | curM.cp;
            end
            anyM    = |flagsM;
            prevVsM = curM.vs;
        end
        #1;
        tickSeen += int'(frame_tick);
        checkOutput("rgb_out",      64'(rgb_out),      64'(curM.rgb));
        checkOutput("draw_out",     64'(draw_out),     64'(curM.draw));
        checkOutput("video_on_out", 64'(video_on_out), 64'(curM.vid));
        checkOutput("hsync_out",    64'(hsync_out),    64'(curM.hs));
        checkOutput("vsync_out",    64'(vsync_out),    64'(curM.vs));
        checkOutput("coll_flags",   64'(coll_flags),   64'(flagsM));
        checkOutput("coll_any",     64'(coll_any),     64'(anyM));
        checkOutput("frame_tick",   64'(frame_tick),   64'(tickM));
    endtask

    task automatic hold(input int n, input logic [CH-1:0] v, input logic [CH-1:0] a,
                        input logic vid, input logic vs);
        for (int k = 0; k < n; k++) applyStimulus(v, a, vid, SI, vs, 1'b0, 1'b0);
    endtask

    // One frame: idle, a single pixel v, idle, then vsync active for 6 cycles.
    task automatic oneFrame(input logic [CH-1:0] v, input logic vid);
        hold(4, NONE, ALL, 1'b1, SI);
        applyStimulus(v, ALL, vid, SI, SI, 1'b0, 1'b0);
        hold(4, NONE, ALL, 1'b1, SI);
        tickSeen = 0;
        hold(6, NONE, ALL, 1'b1, SA);
    endtask

    initial begin
        resetPix = '{rgb: '0, draw: 1'b0, vid: 1'b0, hs: SI, vs: SI, cp: '0};
        rgbVec   = {$urandom, $urandom, $urandom};

        // Reset values
        for (int k = 0; k < 3; k++) applyStimulus(ALL, ALL, 1'b1, SA, SA, 1'b0, 1'b1);
        checkOutput("rst_rgb",   64'(rgb_out),      64'(0));
        checkOutput("rst_draw",  64'(draw_out),     64'(0));
        checkOutput("rst_vid",   64'(video_on_out), 64'(0));
        checkOutput("rst_hs",    64'(hsync_out),    64'(SI));
        checkOutput("rst_vs",    64'(vsync_out),    64'(SI));
        checkOutput("rst_flags", 64'(coll_flags),   64'(0));
        checkOutput("rst_any",   64'(coll_any),     64'(0));
        checkOutput("rst_tick",  64'(frame_tick),   64'(0));

        // Priority: ch3 beats ch12; dropping ch3 active exposes ch12
        rgbVec[3*RW +: RW]  = 3'b100;
        rgbVec[12*RW +: RW] = 3'b010;
        hold(4, (CH'(1) << 3) | (CH'(1) << 12), ALL, 1'b1, SI);
        checkOutput("tp_ch3_wins", 64'(rgb_out), 64'(3'b100));
        hold(4, (CH'(1) << 3) | (CH'(1) << 12), ALL & ~(CH'(1) << 3), 1'b1, SI);
        checkOutput("tp_ch12", 64'(rgb_out), 64'(3'b010));

        // Background, then blanking forces black
        hold(4, NONE, ALL, 1'b1, SI);
        checkOutput("tp_bg_rgb",  64'(rgb_out),  64'(BG));
        checkOutput("tp_bg_draw", 64'(draw_out), 64'(0));
        hold(4, CH'(1), ALL, 1'b0, SI);
        checkOutput("tp_blank_rgb",  64'(rgb_out),  64'(0));
        checkOutput("tp_blank_draw", 64'(draw_out), 64'(0));

        // Sync pattern follows with the pipeline delay
        for (int k = 0; k < 16; k++) begin
            applyStimulus(NONE, ALL, 1'b1, logic'(k % 3 == 0), logic'((k / 2) % 2), 1'b0, 1'b0);
        end

        // Clear, then A/B overlap on ch2 and ch20 for one pixel
        hold(4, NONE, ALL, 1'b1, SI);
        applyStimulus(NONE, ALL, 1'b1, SI, SI, 1'b1, 1'b0);
        oneFrame((CH'(1) << 2) | (CH'(1) << 20), 1'b1);
        checkOutput("coll_ab_flags", 64'(coll_flags), 64'(32'h0010_0004));
        checkOutput("coll_ab_any",   64'(coll_any),   64'(1));
        checkOutput("coll_ab_ticks", 64'(tickSeen),   64'(1));
        oneFrame(NONE, 1'b1);
        checkOutput("coll_none_flags", 64'(coll_flags), 64'(0));

        // Same-class overlap and blanked overlap never collide
        oneFrame((CH'(1) << 2) | (CH'(1) << 5), 1'b1);
        checkOutput("coll_aa_flags", 64'(coll_flags), 64'(0));
        oneFrame((CH'(1) << 2) | (CH'(1) << 20), 1'b0);
        checkOutput("coll_blank_flags", 64'(coll_flags), 64'(0));

        // Clear coinciding with the boundary wins, tick still pulses
        hold(4, NONE, ALL, 1'b1, SI);
        applyStimulus((CH'(1) << 2) | (CH'(1) << 20), ALL, 1'b1, SI, SI, 1'b0, 1'b0);
        hold(4, NONE, ALL, 1'b1, SI);
        applyStimulus(NONE, ALL, 1'b1, SI, SA, 1'b0, 1'b0);
        applyStimulus(NONE, ALL, 1'b1, SI, SA, 1'b0, 1'b0);
        applyStimulus(NONE, ALL, 1'b1, SI, SA, 1'b1, 1'b0);
        checkOutput("clr_bnd_tick",  64'(frame_tick), 64'(1));
        checkOutput("clr_bnd_flags", 64'(coll_flags), 64'(0));
        hold(3, NONE, ALL, 1'b1, SA);

        // Reset mid-frame after an overlap: next boundary publishes nothing
        hold(4, NONE, ALL, 1'b1, SI);
        applyStimulus((CH'(1) << 2) | (CH'(1) << 20), ALL, 1'b1, SI, SI, 1'b0, 1'b0);
        hold(4, NONE, ALL, 1'b1, SI);
        applyStimulus(NONE, ALL, 1'b1, SI, SI, 1'b0, 1'b1);
        applyStimulus(NONE, ALL, 1'b1, SI, SI, 1'b0, 1'b1);
        oneFrame(NONE, 1'b1);
        checkOutput("rst_mid_flags", 64'(coll_flags), 64'(0));
        checkOutput("rst_mid_ticks", 64'(tickSeen),   64'(1));

        // Randomised traffic against the model
        begin
            logic vsR;
            vsR = SI;
            for (int k = 0; k < 400; k++) begin
                rgbVec = {$urandom, $urandom, $urandom};
                if ($urandom_range(0, 19) == 0) vsR = ~vsR;
                applyStimulus($urandom & $urandom & $urandom,
                              ~($urandom & $urandom & $urandom),
                              logic'($urandom_range(0, 7) != 0),
                              logic'($urandom_range(0, 1)),
                              vsR,
                              logic'($urandom_range(0, 59) == 0),
                              logic'($urandom_range(0, 149) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
